uart_pixel_loader: RTL and testbench

Controller that sequences the `uart_rx` byte stream into the frame buffer. It waits for a sync byte, then writes exactly `IMG_W*IMG_H` 3-bit grayscale pixels (byte values 0–7) to consecutive frame-buffer addresses, and reports frame completion or an abort reason. It sits between `uart_rx` (`data_out`/`data_valid`/`frame_error`) and the frame-buffer write port read by the display path. Single 50 MHz clock domain.

---
 rtl/uart_pixel_loader.sv | 219 +++++++++++++++++++++
 tb/tb_uart_pixel_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pixel_loader.sv
// uart_pixel_loader: sequences the uart_rx byte stream into the frame buffer.
// Waits for SYNC_BYTE, writes IMG_W*IMG_H 3-bit pixels to consecutive
// addresses, then reports frame completion or an abort reason.
// Optional build macro: PIXEL_CHECKSUM_EN adds a CHECK state that expects a
// trailing byte equal to the XOR of all pixel bytes of the frame.
module uart_pixel_loader #(
  parameter int unsigned IMG_W          = 160,
  parameter int unsigned IMG_H          = 120,
  parameter int unsigned ADDR_W         = 15,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_frame_error,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [2:0]        fb_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [7:0]        frame_count
);

  localparam int unsigned       NumPixels = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(NumPixels - 1);
  localparam int unsigned       TmoW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0]   TmoMax    = TmoW'(TIMEOUT_CYCLES);

  localparam logic [2:0] ErrNone    = 3'b000;
  localparam logic [2:0] ErrUart    = 3'b001;
  localparam logic [2:0] ErrRange   = 3'b010;
  localparam logic [2:0] ErrTimeout = 3'b011;
  localparam logic [2:0] ErrEnable  = 3'b101;
`ifdef PIXEL_CHECKSUM_EN
  localparam logic [2:0] ErrCsum    = 3'b100;

  typedef enum logic [2:0] {StIdle, StRecv, StCheck, StDone, StAbort} state_e;
`else
  typedef enum logic [2:0] {StIdle, StRecv, StDone, StAbort} state_e;
`endif

  state_e            state_q, state_d;
  logic [2:0]        err_code_q, err_code_d;
  logic              sync_accept;
  logic              pix_accept;
  logic              in_frame;
  logic              tmo_hit;
  logic [TmoW-1:0]   tmo_q;
  logic [ADDR_W-1:0] pix_cnt_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic [2:0]        fb_data_q;
  logic              fb_we_q;
  logic              frame_done_q;
  logic [7:0]        frame_count_q;
`ifdef PIXEL_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

`ifdef PIXEL_CHECKSUM_EN
  assign in_frame = (state_q == StRecv) || (state_q == StCheck);
`else
  assign in_frame = (state_q == StRecv);
`endif

  // Expiry only once the counter has sat at the limit for a full cycle, so a
  // byte arriving in that cycle still wins.
  assign tmo_hit = (tmo_q == TmoMax);

  // State register; reset mid-frame simply drops back to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      err_code_q <= ErrNone;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state decode; abort priority is enable > frame error > byte > timeout.
  always_comb begin
    state_d     = state_q;
    err_code_d  = err_code_q;
    sync_accept = 1'b0;
    pix_accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d     = StRecv;
          err_code_d  = ErrNone;
          sync_accept = 1'b1;
        end
      end
      StRecv: begin
        if (!enable) begin
          state_d    = StAbort;
          err_code_d = ErrEnable;
        end else if (rx_frame_error) begin
          state_d    = StAbort;
          err_code_d = ErrUart;
        end else if (rx_valid) begin
          if (rx_data > 8'd7) begin
            state_d    = StAbort;
            err_code_d = ErrRange;
          end else begin
            pix_accept = 1'b1;
            if (pix_cnt_q == LastAddr) begin
`ifdef PIXEL_CHECKSUM_EN
              state_d = StCheck;
`else
              state_d = StDone;
`endif
            end
          end
        end else if (tmo_hit) begin
          state_d    = StAbort;
          err_code_d = ErrTimeout;
        end
      end
`ifdef PIXEL_CHECKSUM_EN
      StCheck: begin
        if (!enable) begin
          state_d    = StAbort;
          err_code_d = ErrEnable;
        end else if (rx_frame_error) begin
          state_d    = StAbort;
          err_code_d = ErrUart;
        end else if (rx_valid) begin
          if (rx_data == csum_q) begin
            state_d = StDone;
          end else begin
            state_d    = StAbort;
            err_code_d = ErrCsum;
          end
        end else if (tmo_hit) begin
          state_d    = StAbort;
          err_code_d = ErrTimeout;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Write port: address/data latched with the strobe, held between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= 3'd0;
      pix_cnt_q <= '0;
    end else begin
      fb_we_q <= pix_accept;
      if (sync_accept) begin
        fb_addr_q <= '0;
        pix_cnt_q <= '0;
      end else if (pix_accept) begin
        fb_addr_q <= pix_cnt_q;
        fb_data_q <= rx_data[2:0];
        // Counter parks on the last address; the frame ends there.
        if (pix_cnt_q != LastAddr) begin
          pix_cnt_q <= pix_cnt_q + ADDR_W'(1);
        end
      end
    end
  end

  // Inter-byte idle counter, saturating at the limit while inside a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (!in_frame || rx_valid) begin
      tmo_q <= '0;
    end else if (!tmo_hit) begin
      tmo_q <= tmo_q + TmoW'(1);
    end
  end

`ifdef PIXEL_CHECKSUM_EN
  // Running XOR of the accepted pixel bytes of the current frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= 8'd0;
    end else if (sync_accept) begin
      csum_q <= 8'd0;
    end else if (pix_accept) begin
      csum_q <= csum_q ^ rx_data;
    end
  end
`endif

  // Completion pulse and good-frame counter, both one cycle after DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done_q  <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      frame_done_q <= (state_q == StDone);
      if (state_q == StDone) begin
        frame_count_q <= frame_count_q + 8'd1;
      end
    end
  end

  assign fb_we       = fb_we_q;
  assign fb_addr     = fb_addr_q;
  assign fb_data     = fb_data_q;
  assign busy        = in_frame;
  assign frame_done  = frame_done_q;
  assign err         = (state_q == StAbort);
  assign err_code    = err_code_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Directed bench for uart_pixel_loader with a 4x2 image and 100-cycle timeout.
module tb_uart_pixel_loader;

  localparam int unsigned IMG_W  = 4;
  localparam int unsigned IMG_H  = 2;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned TMO    = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b1;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_valid = 1'b0;
  logic              rx_frame_error = 1'b0;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [2:0]        fb_data;
  logic              busy;
  logic              frame_done;
  logic              err;
  logic [2:0]        err_code;
  logic [7:0]        frame_count;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  int snap_we;
  int snap_err;

  uart_pixel_loader #(
    .IMG_W         (IMG_W),
    .IMG_H         (IMG_H),
    .ADDR_W        (ADDR_W),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_frame_error(rx_frame_error),
    .fb_we         (fb_we),
    .fb_addr       (fb_addr),
    .fb_data       (fb_data),
    .busy          (busy),
    .frame_done    (frame_done),
    .err           (err),
    .err_code      (err_code),
    .frame_count   (frame_count)
  );

  always #10 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (fb_we) we_cnt++;
    if (err) err_cnt++;
    if (frame_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; returns just after the edge that sampled it.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  // Full good frame: sync, pixels 0..7 (plus checksum if built in).
  task automatic run_frame(input int exp_count);
    tick(19);
    send(8'hA5);
    check("busy_after_sync", 32'(busy), 1);
    check("err_code_cleared", 32'(err_code), 0);
    for (int i = 0; i < 8; i++) begin
      tick(19);
      send(8'(i));
      check("pix_we", 32'(fb_we), 1);
      check("pix_addr", 32'(fb_addr), 32'(i));
      check("pix_data", 32'(fb_data), 32'(i));
    end
`ifdef PIXEL_CHECKSUM_EN
    check("wait_csum_busy", 32'(busy), 1);
    tick(19);
    send(8'h00);
    check("csum_no_write", 32'(fb_we), 0);
`endif
    check("done_not_early", 32'(frame_done), 0);
    tick(1);
    check("frame_done", 32'(frame_done), 1);
    check("frame_count", 32'(frame_count), 32'(exp_count));
    check("idle_after_done", 32'(busy), 0);
    tick(1);
    check("frame_done_one_cycle", 32'(frame_done), 0);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    check("rst_fb_we", 32'(fb_we), 0);
    check("rst_fb_addr", 32'(fb_addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_frame_count", 32'(frame_count), 0);

    // Good frame.
    snap_we = we_cnt;
    snap_err = err_cnt;
    run_frame(1);
    check("good_writes", 32'(we_cnt - snap_we), 8);
    check("good_no_err", 32'(err_cnt - snap_err), 0);
    check("good_done_cnt", 32'(done_cnt), 1);

    // Out-of-range byte.
    snap_we = we_cnt;
    tick(19);
    send(8'hA5);
    tick(19);
    send(8'h01);
    tick(19);
    send(8'h02);
    tick(19);
    send(8'h09);
    check("range_err", 32'(err), 1);
    check("range_code", 32'(err_code), 2);
    check("range_no_write", 32'(fb_we), 0);
    check("range_busy_low", 32'(busy), 0);
    tick(1);
    check("range_err_pulse", 32'(err), 0);
    check("range_code_held", 32'(err_code), 2);
    check("range_writes", 32'(we_cnt - snap_we), 2);
    run_frame(2);

    // UART frame error together with a byte.
    snap_we = we_cnt;
    tick(19);
    send(8'hA5);
    tick(19);
    send(8'h03);
    tick(19);
    rx_frame_error = 1'b1;
    send(8'h04);
    rx_frame_error = 1'b0;
    check("uart_err", 32'(err), 1);
    check("uart_code", 32'(err_code), 1);
    check("uart_no_write", 32'(fb_we), 0);
    check("uart_writes", 32'(we_cnt - snap_we), 1);
    tick(19);
    snap_err = err_cnt;
    rx_frame_error = 1'b1;
    tick(1);
    rx_frame_error = 1'b0;
    tick(2);
    check("idle_ignores_ferr", 32'(err_cnt - snap_err), 0);
    check("idle_ferr_busy", 32'(busy), 0);

    // Timeout: silence after the last byte.
    tick(19);
    send(8'hA5);
    tick(19);
    send(8'h05);
    tick(TMO);
    check("tmo_not_yet", 32'(err), 0);
    check("tmo_still_busy", 32'(busy), 1);
    tick(1);
    check("tmo_err", 32'(err), 1);
    check("tmo_code", 32'(err_code), 3);

    // Byte just before expiry keeps the frame alive.
    tick(19);
    send(8'hA5);
    tick(19);
    send(8'h05);
    tick(98);
    send(8'h06);
    check("tmo_late_byte_we", 32'(fb_we), 1);
    check("tmo_late_byte_addr", 32'(fb_addr), 1);
    tick(1);
    check("tmo_late_byte_busy", 32'(busy), 1);
    check("tmo_late_no_err", 32'(err), 0);
    tick(TMO);
    check("tmo_restart_err", 32'(err), 1);
    check("tmo_restart_code", 32'(err_code), 3);

    // Enable drop after three pixels.
    tick(19);
    send(8'hA5);
    for (int i = 0; i < 3; i++) begin
      tick(19);
      send(8'(i));
    end
    tick(5);
    enable = 1'b0;
    tick(1);
    check("en_err", 32'(err), 1);
    check("en_code", 32'(err_code), 5);
    check("en_busy_low", 32'(busy), 0);
    enable = 1'b1;

    // Reset after three pixels.
    tick(19);
    send(8'hA5);
    for (int i = 0; i < 3; i++) begin
      tick(19);
      send(8'(i + 4));
    end
    tick(5);
    snap_err = err_cnt;
    rst = 1'b1;
    tick(1);
    check("mid_rst_addr", 32'(fb_addr), 0);
    check("mid_rst_data", 32'(fb_data), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_count", 32'(frame_count), 0);
    check("mid_rst_code", 32'(err_code), 0);
    rst = 1'b0;
    tick(2);
    check("mid_rst_no_err", 32'(err_cnt - snap_err), 0);
    run_frame(1);

`ifdef PIXEL_CHECKSUM_EN
    // Wrong checksum byte.
    tick(19);
    send(8'hA5);
    for (int i = 0; i < 8; i++) begin
      tick(19);
      send(8'(i));
    end
    tick(19);
    send(8'h01);
    check("csum_err", 32'(err), 1);
    check("csum_code", 32'(err_code), 4);
    tick(1);
    check("csum_count_kept", 32'(frame_count), 1);
`endif

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
